// File: rtl/ripple_pkg.sv
// ripple_pkg: shared constants for the ripple control stage.
//   SPEED_MAX         highest speed level (period = BASE_PERIOD >> 3)
//   DIR_UP / DIR_DOWN shift_dir encodings (toward led7 / toward led0)
//   LED_POS_W         led_pos width for the default 8-LED ripple
//   pos_width()       led_pos width for any NUM_LEDS
package ripple_pkg;

    localparam logic [1:0] SPEED_MAX = 2'd3;
    localparam logic       DIR_UP    = 1'b0;
    localparam logic       DIR_DOWN  = 1'b1;
    localparam int         LED_POS_W = $clog2(8);

    // Keeps led_pos at least one bit wide for degenerate LED counts.
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of each button in the debouncer bank.
    typedef enum logic [1:0] {
        BTN_FASTER = 2'd0,
        BTN_SLOWER = 2'd1,
        BTN_DIR    = 2'd2,
        BTN_PAUSE  = 2'd3
    } btn_idx_e;

endpackage

// File: rtl/ripple_ctrl_btn_debounce.sv
// btn_debounce: one pushbutton conditioner.
//   2-flop synchronizer -> stability counter -> rising-edge press pulse.
//   The synchronized level must hold for DEBOUNCE_CYCLES counter steps before
//   it becomes the accepted level. A clean raw edge yields a pulse
//   2 + DEBOUNCE_CYCLES cycles later. Releases are accepted silently.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   btn       raw asynchronous button level (active-high)
//   press     one-cycle pulse on an accepted 0->1 change
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2, level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            // sync1 != sync2 means sync2 is about to change: restart the count
            // so only an uninterrupted run of the new level is accepted.
            if (sync1 != sync2 || sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ripple_ctrl.sv
// ripple_ctrl: tick/direction generator feeding the rippling-LED shifter.
//   Four debounced buttons adjust speed (4 levels), toggle direction and
//   toggle pause. A rate counter emits a one-cycle shift_tick every
//   BASE_PERIOD >> speed_level cycles; led_pos tracks the lit LED.
// Build option: define RIPPLE_PINGPONG_EN for automatic direction reversal at
//   the ends of the ripple (led_pos NUM_LEDS-1 -> down, 0 -> up).
// Ports:
//   clk, rst                asynchronous active-high reset
//   btn_faster/btn_slower   raw buttons, step speed_level up/down (saturating)
//   btn_dir, btn_pause      raw buttons, toggle shift_dir / paused
//   shift_tick              one-cycle shift strobe
//   shift_dir               0 = toward led7, 1 = toward led0
//   paused                  ticks suppressed while high
//   speed_level             0 slowest .. 3 fastest
//   led_pos                 lit LED index after the latest tick
module ripple_ctrl
    import ripple_pkg::*;
#(
    parameter int BASE_PERIOD     = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_LEDS        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             btn_faster,
    input  logic                             btn_slower,
    input  logic                             btn_dir,
    input  logic                             btn_pause,
    output logic                             shift_tick,
    output logic                             shift_dir,
    output logic                             paused,
    output logic [1:0]                       speed_level,
    output logic [pos_width(NUM_LEDS)-1:0]   led_pos
);

    localparam int PW = pos_width(NUM_LEDS);
    localparam int CW = $clog2(BASE_PERIOD) + 1;
    localparam logic [PW-1:0] POS_LAST = PW'(NUM_LEDS - 1);

    logic [3:0] raw, press;
    assign raw = {btn_pause, btn_dir, btn_slower, btn_faster};

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn   (raw[i]),
            .press (press[i])
        );
    end

    logic p_fast, p_slow, p_dir, p_pause;
    assign p_fast  = press[BTN_FASTER];
    assign p_slow  = press[BTN_SLOWER];
    assign p_dir   = press[BTN_DIR];
    assign p_pause = press[BTN_PAUSE];

    // Simultaneous faster+slower cancel; saturated presses are ignored.
    logic speed_up, speed_dn;
    assign speed_up = p_fast & ~p_slow & (speed_level != SPEED_MAX);
    assign speed_dn = p_slow & ~p_fast & (speed_level != 2'd0);

    logic [CW-1:0] cnt, cnt_next, period;
    logic          terminal, tick_next, dir_next;
    logic [PW-1:0] pos_next;

    assign period   = CW'(BASE_PERIOD) >> speed_level;
    assign terminal = (cnt == period - 1'b1);

    // Position after a tick, stepping in the current (pre-toggle) direction.
    always_comb begin
        pos_next = led_pos;
        if (shift_dir == DIR_UP)
            pos_next = (led_pos == POS_LAST) ? '0 : led_pos + 1'b1;
        else
            pos_next = (led_pos == '0) ? POS_LAST : led_pos - 1'b1;
    end

    always_comb begin
        cnt_next  = cnt;
        tick_next = 1'b0;
        if (speed_up || speed_dn) begin
            cnt_next = '0;
        end else if (!paused) begin
            if (!terminal) begin
                cnt_next = cnt + 1'b1;
            end else if (!p_pause) begin
                cnt_next  = '0;
                tick_next = 1'b1;
            end
            // pause landing on terminal count: hold at period-1, no tick
        end

        dir_next = shift_dir ^ p_dir;
`ifdef RIPPLE_PINGPONG_EN
        // Reaching an end of the ripple overrides a coincident dir press.
        if (tick_next) begin
            if (pos_next == POS_LAST)
                dir_next = DIR_DOWN;
            else if (pos_next == '0)
                dir_next = DIR_UP;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            shift_tick  <= 1'b0;
            shift_dir   <= DIR_UP;
            paused      <= 1'b0;
            speed_level <= 2'd0;
            led_pos     <= '0;
        end else begin
            cnt        <= cnt_next;
            shift_tick <= tick_next;
            shift_dir  <= dir_next;
            paused     <= paused ^ p_pause;
            if (speed_up)
                speed_level <= speed_level + 2'd1;
            else if (speed_dn)
                speed_level <= speed_level - 2'd1;
            if (tick_next)
                led_pos <= pos_next;
        end
    end

endmodule

// File: doc/ripple_ctrl.md
Name: ripple_ctrl

Overview:
Control stage directly upstream of the rippling-LED shifter. Debounces four board pushbuttons and generates a one-cycle shift strobe plus a direction bit, replacing the fixed 50M-cycle internal count. The rate is selectable over four speed levels, and shifting can be paused. The downstream LED stage consumes shift_tick/shift_dir and rotates its one-hot pattern once per strobe.

Parameters:
BASE_PERIOD  50000000  cycles between ticks at speed level 0 (one shift per second at 50 MHz)
DEBOUNCE_CYCLES  1000000  cycles a synchronized button level must stay stable before it is accepted
NUM_LEDS  8  positions in the downstream ripple; used by the position tracker

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_faster  input  1  raw pushbutton, asynchronous, active-high
btn_slower  input  1  raw pushbutton, asynchronous, active-high
btn_dir  input  1  raw pushbutton; a press toggles direction
btn_pause  input  1  raw pushbutton; a press toggles pause
shift_tick  output  1  one-cycle strobe: downstream shifts once
shift_dir  output  1  0 = ripple toward led7, 1 = toward led0
paused  output  1  1 while ticks are suppressed
speed_level  output  2  0 = slowest, 3 = fastest
led_pos  output  $clog2(NUM_LEDS)  index of the lit LED after the most recent tick

Behaviour:
- Reset (async, active-high): shift_tick=0, shift_dir=0, paused=0, speed_level=0, led_pos=0. Rate counter is cleared. Debouncer state is cleared (accepted level 0). On release, the first tick arrives after a full period.
- Button path, per button:
  - 2-flop synchronizer.
  - Stability counter: resets on any change of the synchronized level; the new level is accepted when the counter reaches DEBOUNCE_CYCLES-1.
  - A 0->1 change of the accepted level gives a one-cycle press pulse.
  - Latency from a clean raw edge to the pulse: 2 + DEBOUNCE_CYCLES cycles.
  - Releases produce no pulse.
- Period: BASE_PERIOD >> speed_level. Levels 0..3 give BASE_PERIOD, /2, /4, /8.
- Rate counter:
  - Counts 0..period-1.
  - At period-1 while paused=0: shift_tick=1 for exactly that cycle, then the counter returns to 0.
  - While paused=1 the counter holds its value and no ticks are issued.
- faster/slower pulses:
  - Step speed_level by ±1, saturating at 3 and at 0.
  - A saturated press is ignored and does not clear the counter.
  - An effective change clears the counter to 0 in the same cycle, with no tick that cycle.
  - Both pulses in the same cycle: both ignored.
- dir pulse: toggles shift_dir registered. A tick in the same cycle uses the old direction.
- pause pulse: toggles paused.
  - If the pause pulse coincides with terminal count while running, the pause wins: no tick, and the counter holds at period-1.
  - Unpausing at terminal count ticks on the next cycle.
- led_pos: on each tick, +1 mod NUM_LEDS if shift_dir=0, otherwise -1 mod NUM_LEDS. Wraps 7->0 and 0->7.
- All outputs are registered. shift_tick never asserts on two consecutive cycles unless period=1; period=1 is legal only for test parameters.

Optional Feature:
RIPPLE_PINGPONG_EN
- Defined: direction reverses automatically. When a tick moves led_pos to NUM_LEDS-1, shift_dir is set to 1 on that cycle; when a tick moves it to 0, shift_dir is set to 0. A dir press still toggles shift_dir; if it coincides with an auto-reverse, the auto-reverse wins.
- Undefined: no auto-reverse; led_pos wraps modulo NUM_LEDS as above.

Decomposition:
- Package ripple_pkg:
  - SPEED_MAX = 2'd3
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1
  - width localparam for led_pos
- One sub-module, btn_debounce (synchronizer + stability counter + press-pulse generator, parameter DEBOUNCE_CYCLES), instantiated four times. Rate counter and control logic stay in ripple_ctrl.

Test Plan:
(All scenarios use BASE_PERIOD=16, DEBOUNCE_CYCLES=4.)
- Reset release, no buttons -> first shift_tick 16 cycles after rst deasserts, then every 16 cycles; led_pos runs 1,2,...,7,0.
- btn_faster bounces 0/1 every cycle for 3 cycles, then holds 1 -> exactly one press pulse; speed_level=1; counter clears; next tick after 8 cycles.
- 4 faster presses, then 1 more -> speed_level saturates at 3 with period 2; the fifth press changes nothing and does not disturb tick spacing.
- btn_pause pulse lands at counter=15 -> no tick; paused=1; no ticks for 100 cycles; second pause press -> tick 1 cycle later.
- btn_dir press at led_pos=0 -> next tick gives led_pos=7, shift_dir=1.
- With RIPPLE_PINGPONG_EN, 7 ticks from reset -> led_pos=7, shift_dir flips to 1; next tick gives led_pos=6; reaching 0 flips shift_dir back to 0.
